// File: rtl/vid_palette_ctl_pkg.sv
// Shared palette geometry and grant encoding for the palette controller slice.
package vid_palette_ctl_pkg;
  localparam int PAL_DEPTH = 512;
  localparam int PAL_AW    = 9;
  localparam int PAL_DW    = 32;
  localparam int PAL_CW    = 10;

  typedef logic [PAL_AW-1:0] pal_addr_t;
  typedef logic [PAL_DW-1:0] pal_data_t;
  typedef logic [PAL_CW-1:0] pal_cnt_t;

  typedef enum logic [1:0] {GNT_NONE, GNT_CPU, GNT_LD} gnt_e;
endpackage

// File: rtl/vid_palette_ctl_if.sv
// CPU, loader config, stream and palette-memory signals of the palette controller.
interface vid_palette_ctl_if;
  import vid_palette_ctl_pkg::*;

  pal_addr_t cpu_addr;
  pal_data_t cpu_wdata;
  logic      cpu_wen;
  logic      cpu_ren;
  pal_data_t cpu_rdata;
  logic      cpu_ready;

  logic      ld_start;
  pal_addr_t ld_base;
  pal_cnt_t  ld_count;
  logic      ld_busy;
  logic      ld_done;

  logic      st_valid;
  pal_data_t st_data;
  logic      st_ready;

  pal_addr_t pm_addr;
  pal_data_t pm_din;
  logic      pm_wr;
  logic      pm_clken;
  pal_data_t pm_q;

  modport slave (
    input  cpu_addr, cpu_wdata, cpu_wen, cpu_ren, ld_start, ld_base, ld_count,
           st_valid, st_data, pm_q,
    output cpu_rdata, cpu_ready, ld_busy, ld_done, st_ready,
           pm_addr, pm_din, pm_wr, pm_clken
  );

  modport master (
    output cpu_addr, cpu_wdata, cpu_wen, cpu_ren, ld_start, ld_base, ld_count,
           st_valid, st_data, pm_q,
    input  cpu_rdata, cpu_ready, ld_busy, ld_done, st_ready,
           pm_addr, pm_din, pm_wr, pm_clken
  );
endinterface

// File: rtl/vid_palette_ldseq.sv
// Loader sequencer: latches base/count, walks idx per accepted beat, flags busy/done.
module vid_palette_ldseq
  import vid_palette_ctl_pkg::*;
(
  input  logic      clk,
  input  logic      reset_n,
  input  logic      start,
  input  pal_addr_t base,
  input  pal_cnt_t  count,
  input  logic      beat,
  output logic      busy,
  output logic      done,
  output pal_addr_t wr_addr
);
  pal_addr_t base_q, base_d;
  pal_cnt_t  count_q, count_d, idx_q, idx_d;
  logic      busy_q, busy_d, done_q, done_d;

  always_comb begin
    base_d  = base_q;
    count_d = count_q;
    idx_d   = idx_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    if (!busy_q) begin
      if (start) begin
        // an empty load completes immediately without touching memory
        if (count != '0) begin
          base_d  = base;
          count_d = count;
          idx_d   = '0;
          busy_d  = 1'b1;
        end else begin
          done_d  = 1'b1;
        end
      end
    end else if (beat) begin
      idx_d = idx_q + pal_cnt_t'(1);
      if (idx_q == count_q - pal_cnt_t'(1)) begin
        busy_d = 1'b0;
        done_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      base_q  <= '0;
      count_q <= '0;
      idx_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      base_q  <= base_d;
      count_q <= count_d;
      idx_q   <= idx_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  // 9-bit add wraps past the top of the palette
  assign wr_addr = base_q + idx_q[PAL_AW-1:0];
  assign busy    = busy_q;
  assign done    = done_q;
endmodule

// File: rtl/vid_palette_ctl.sv
// Palette controller: shares one palette port between CPU accesses and the stream loader.
module vid_palette_ctl
  import vid_palette_ctl_pkg::*;
(
  input  logic              clk,
  input  logic              reset_n,
  vid_palette_ctl_if.slave  bus
);
  logic      cpu_pending;
  logic      outst_q, outst_d;
  logic      pref_q, pref_d;
  gnt_e      gnt;
  pal_addr_t ld_addr;

  assign cpu_pending  = (bus.cpu_wen | bus.cpu_ren) & ~outst_q;
  assign bus.st_ready = bus.ld_busy & ~(cpu_pending & pref_q);

  // st_ready already drops when the CPU has priority, so a beat implies the CPU yields
  always_comb begin
    gnt = GNT_NONE;
    if (reset_n) begin
      if (bus.st_valid & bus.st_ready) gnt = GNT_LD;
      else if (cpu_pending)            gnt = GNT_CPU;
    end
  end

  always_comb begin
    outst_d = (gnt == GNT_CPU);
    pref_d  = pref_q;
    if (gnt == GNT_LD)  pref_d = 1'b1;
    if (gnt == GNT_CPU) pref_d = 1'b0;
  end

  always_comb begin
    bus.pm_addr  = '0;
    bus.pm_din   = '0;
    bus.pm_wr    = 1'b0;
    bus.pm_clken = 1'b0;
    case (gnt)
      GNT_LD: begin
        bus.pm_addr  = ld_addr;
        bus.pm_din   = bus.st_data;
        bus.pm_wr    = 1'b1;
        bus.pm_clken = 1'b1;
      end
      GNT_CPU: begin
        bus.pm_addr  = bus.cpu_addr;
        bus.pm_din   = bus.cpu_wdata;
        bus.pm_wr    = bus.cpu_wen;
        bus.pm_clken = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      outst_q <= 1'b0;
      pref_q  <= 1'b1;
    end else begin
      outst_q <= outst_d;
      pref_q  <= pref_d;
    end
  end

  // the outstanding flag is exactly the acknowledge cycle; pm_q holds the read then
  assign bus.cpu_ready = outst_q;
  assign bus.cpu_rdata = outst_q ? bus.pm_q : '0;

  vid_palette_ldseq u_ldseq (
    .clk     (clk),
    .reset_n (reset_n),
    .start   (bus.ld_start),
    .base    (bus.ld_base),
    .count   (bus.ld_count),
    .beat    (gnt == GNT_LD),
    .busy    (bus.ld_busy),
    .done    (bus.ld_done),
    .wr_addr (ld_addr)
  );
endmodule

// File: tb/tb_vid_palette_ctl.sv
// Directed + randomized bench for vid_palette_ctl with a registered-read palette RAM.
module tb_vid_palette_ctl;
  import vid_palette_ctl_pkg::*;

  logic clk = 1'b0;
  logic reset_n;
  always #5 clk = ~clk;

  vid_palette_ctl_if bus();
  vid_palette_ctl dut (.clk(clk), .reset_n(reset_n), .bus(bus));

  logic [31:0] ram     [PAL_DEPTH];
  logic [31:0] ref_mem [PAL_DEPTH];
  int total = 0;
  int bad   = 0;
  int wr_cnt = 0;

  always @(posedge clk) begin
    if (bus.pm_clken) begin
      if (bus.pm_wr) ram[bus.pm_addr] <= bus.pm_din;
      else           bus.pm_q <= ram[bus.pm_addr];
    end
  end

  always @(posedge clk) if (reset_n && bus.pm_clken && bus.pm_wr) wr_cnt++;

  task automatic nxt;
    @(posedge clk);
    #1;
  endtask

  task automatic settle;
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] wrap(input int base, input int i);
    return 32'((base + i) % PAL_DEPTH);
  endfunction

  task automatic cpu_op(input bit we, input bit both, input int a, input logic [31:0] d);
    nxt;
    bus.cpu_wen = we; bus.cpu_ren = !we | both;
    bus.cpu_addr = pal_addr_t'(a); bus.cpu_wdata = d;
    settle;
    chk("cpu_issue", 32'(bus.pm_clken), 1);
    chk("cpu_iss_wr", 32'(bus.pm_wr), 32'(we));
    chk("cpu_iss_addr", 32'(bus.pm_addr), 32'(a));
    if (we) chk("cpu_iss_din", bus.pm_din, d);
    chk("cpu_rdy_early", 32'(bus.cpu_ready), 0);
    nxt; settle;
    chk("cpu_rdy", 32'(bus.cpu_ready), 1);
    chk("cpu_no_reissue", 32'(bus.pm_clken), 0);
    if (we) ref_mem[a] = d;
    else    chk("cpu_rdata", bus.cpu_rdata, ref_mem[a]);
    bus.cpu_wen = 1'b0; bus.cpu_ren = 1'b0;
  endtask

  task automatic run_load(input int base, input int cnt, input bit gaps, input bit poke);
    int i, cyc, w0;
    logic [31:0] dat;
    w0 = wr_cnt;
    nxt;
    bus.ld_start = 1'b1; bus.ld_base = pal_addr_t'(base); bus.ld_count = pal_cnt_t'(cnt);
    settle;
    nxt;
    bus.ld_start = 1'b0; bus.ld_base = pal_addr_t'($urandom); bus.ld_count = pal_cnt_t'($urandom);
    settle;
    chk("ld_busy_start", 32'(bus.ld_busy), 32'(cnt != 0));
    chk("ld_done_start", 32'(bus.ld_done), 32'(cnt == 0));
    if (cnt == 0) begin
      chk("ld0_no_wr", 32'(bus.pm_wr), 0);
      nxt; settle;
      chk("ld0_done_once", 32'(bus.ld_done), 0);
      chk("ld0_busy", 32'(bus.ld_busy), 0);
      chk("ld0_wr_count", 32'(wr_cnt - w0), 0);
    end else begin
      i = 0; cyc = 0;
      while (i < cnt && cyc < 64) begin
        nxt;
        dat = $urandom;
        bus.st_valid = gaps ? ($urandom_range(0, 1) == 1) : 1'b1;
        bus.st_data  = dat;
        if (poke && i == 1) begin
          bus.ld_start = 1'b1; bus.ld_base = '0; bus.ld_count = 10'd5;
        end else bus.ld_start = 1'b0;
        settle;
        if (!gaps) chk("ld_st_ready", 32'(bus.st_ready), 1);
        if (bus.st_valid && bus.st_ready) begin
          chk("ld_wr", 32'(bus.pm_wr), 1);
          chk("ld_addr", 32'(bus.pm_addr), wrap(base, i));
          chk("ld_din", bus.pm_din, dat);
          ref_mem[wrap(base, i)] = dat;
          i++;
        end else chk("ld_idle", 32'(bus.pm_clken), 0);
        cyc++;
      end
      chk("ld_timeout", 32'(cyc < 64), 1);
      nxt;
      bus.st_valid = 1'b0; bus.ld_start = 1'b0;
      settle;
      chk("ld_done_pulse", 32'(bus.ld_done), 1);
      chk("ld_busy_clr", 32'(bus.ld_busy), 0);
      nxt; settle;
      chk("ld_done_once", 32'(bus.ld_done), 0);
      chk("ld_wr_count", 32'(wr_cnt - w0), 32'(cnt));
    end
  endtask

  initial begin
    int a, b, n, g, last_g, adj, nc, nl, cyc;
    bit prev_cpu;
    int addrs[6];
    for (int k = 0; k < PAL_DEPTH; k++) begin ram[k] = '0; ref_mem[k] = '0; end
    bus.pm_q = '0;
    bus.cpu_addr = '0; bus.cpu_wdata = '0; bus.cpu_wen = 1'b0; bus.cpu_ren = 1'b0;
    bus.ld_start = 1'b0; bus.ld_base = '0; bus.ld_count = '0;
    bus.st_valid = 1'b0; bus.st_data = '0;
    reset_n = 1'b0;
    repeat (3) nxt;
    settle;
    chk("rst_cpu_ready", 32'(bus.cpu_ready), 0);
    chk("rst_ld_busy", 32'(bus.ld_busy), 0);
    chk("rst_ld_done", 32'(bus.ld_done), 0);
    chk("rst_st_ready", 32'(bus.st_ready), 0);
    chk("rst_pm_wr", 32'(bus.pm_wr), 0);
    chk("rst_pm_clken", 32'(bus.pm_clken), 0);
    chk("rst_pm_addr", 32'(bus.pm_addr), 0);
    chk("rst_pm_din", bus.pm_din, 0);
    nxt; reset_n = 1'b1;

    cpu_op(1'b1, 1'b0, 5, 32'h00FF00FF);
    cpu_op(1'b0, 1'b0, 5, '0);
    chk("rd5_model", ref_mem[5], 32'h00FF00FF);

    for (int k = 0; k < 6; k++) begin
      addrs[k] = $urandom_range(0, PAL_DEPTH - 1);
      cpu_op(1'b1, (k == 2), addrs[k], $urandom);
    end
    for (int k = 5; k >= 0; k--) cpu_op(1'b0, 1'b0, addrs[k], '0);

    run_load(3, 4, 1'b0, 1'b0);
    for (int k = 3; k <= 6; k++) cpu_op(1'b0, 1'b0, k, '0);
    run_load(510, 4, 1'b0, 1'b0);
    cpu_op(1'b0, 1'b0, 510, '0); cpu_op(1'b0, 1'b0, 511, '0);
    cpu_op(1'b0, 1'b0, 0, '0);   cpu_op(1'b0, 1'b0, 1, '0);

    run_load(20, 0, 1'b0, 1'b0);
    run_load(200, 3, 1'b0, 1'b1);
    cpu_op(1'b0, 1'b0, 0, '0); cpu_op(1'b0, 1'b0, 202, '0);

    b = $urandom_range(0, PAL_DEPTH - 1);
    n = $urandom_range(1, 6);
    run_load(b, n, 1'b1, 1'b0);
    for (int k = 0; k < n; k++) cpu_op(1'b0, 1'b0, int'(wrap(b, k)), '0);

    // contention: CPU read held throughout a 4-beat load
    cpu_op(1'b1, 1'b0, 77, 32'hCAFE0077);
    nxt;
    bus.ld_start = 1'b1; bus.ld_base = 9'd100; bus.ld_count = 10'd4;
    settle;
    nxt;
    bus.ld_start = 1'b0; bus.cpu_ren = 1'b1; bus.cpu_addr = 9'd77;
    bus.st_valid = 1'b1; bus.st_data = $urandom;
    settle;
    prev_cpu = 1'b0; last_g = 0; adj = 0; nc = 0; nl = 0; cyc = 0;
    while (nl < 4 && cyc < 40) begin
      chk("cnt_ready", 32'(bus.cpu_ready), 32'(prev_cpu));
      if (prev_cpu) chk("cnt_rdata", bus.cpu_rdata, ref_mem[77]);
      g = bus.pm_clken ? (bus.pm_wr ? 2 : 1) : 0;
      if (g == 2) begin
        chk("cnt_ld_addr", 32'(bus.pm_addr), wrap(100, nl));
        ref_mem[wrap(100, nl)] = bus.st_data;
        nl++;
      end
      if (g == 1) begin
        chk("cnt_cpu_addr", 32'(bus.pm_addr), 77);
        nc++;
      end
      if (g != 0) begin
        if (g == last_g) adj++;
        last_g = g;
      end
      prev_cpu = (g == 1);
      nxt;
      if (g == 2) bus.st_data = $urandom;
      if (nl == 4) bus.st_valid = 1'b0;
      settle;
      cyc++;
    end
    chk("cnt_timeout", 32'(cyc < 40), 1);
    chk("cnt_alternate", 32'(adj), 0);
    chk("cnt_no_starve", 32'(nc >= 3), 1);
    chk("cnt_done", 32'(bus.ld_done), 1);
    if (bus.pm_clken) begin
      nxt; bus.cpu_ren = 1'b0; settle;
      chk("cnt_last_ready", 32'(bus.cpu_ready), 1);
      chk("cnt_last_rdata", bus.cpu_rdata, ref_mem[77]);
    end else bus.cpu_ren = 1'b0;
    for (int k = 0; k < 4; k++) cpu_op(1'b0, 1'b0, 100 + k, '0);

    // reset during a load, with a CPU request present
    nxt;
    bus.ld_start = 1'b1; bus.ld_base = 9'd300; bus.ld_count = 10'd4;
    settle;
    nxt; bus.ld_start = 1'b0;
    for (int k = 0; k < 2; k++) begin
      bus.st_valid = 1'b1; bus.st_data = $urandom;
      settle;
      chk("rst_ld_wr", 32'(bus.pm_wr), 1);
      chk("rst_ld_addr", 32'(bus.pm_addr), 32'(300 + k));
      ref_mem[300 + k] = bus.st_data;
      nxt;
    end
    reset_n = 1'b0; bus.cpu_ren = 1'b1; bus.cpu_addr = 9'd5;
    settle;
    chk("rstmid_no_issue", 32'(bus.pm_clken), 0);
    nxt; settle;
    chk("rstmid_busy", 32'(bus.ld_busy), 0);
    chk("rstmid_done", 32'(bus.ld_done), 0);
    chk("rstmid_st_ready", 32'(bus.st_ready), 0);
    chk("rstmid_cpu_ready", 32'(bus.cpu_ready), 0);
    nxt;
    reset_n = 1'b1; bus.st_valid = 1'b0; bus.cpu_ren = 1'b0;
    settle;
    chk("rstmid_no_done", 32'(bus.ld_done), 0);
    nxt; settle;
    chk("rstmid_no_done2", 32'(bus.ld_done), 0);
    run_load(40, 3, 1'b0, 1'b0);
    a = 300;
    cpu_op(1'b0, 1'b0, a, '0); cpu_op(1'b0, 1'b0, a + 1, '0);
    cpu_op(1'b0, 1'b0, a + 2, '0);
    cpu_op(1'b0, 1'b0, 40, '0); cpu_op(1'b0, 1'b0, 42, '0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end
endmodule
